// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory
// and presents instruction/pc4 to the IF/ID register. A bubble (0) is shown
// whenever no valid instruction is available.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,       // active-high despite the name
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_out,
    output logic [31:0] pc4_out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [31:0] pc_q, pc_d;
    logic [1:0]  state_q, state_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic        cancel_q, cancel_d;
    logic [31:0] cancel_pc_q, cancel_pc_d;

    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        complete;

    assign target    = {redirect_pc[31:2], 2'b00};
    assign pc_plus4  = pc_q + 32'd4;
    assign imem_addr = pc_q;
    assign pc4_out   = pc_plus4;
    assign imem_req  = (state_q == FETCH);
    assign complete  = imem_req & imem_ready;

    // Next-state and output decode
    always_comb begin
        pc_d            = pc_q;
        state_d         = state_q;
        hold_buf_d      = hold_buf_q;
        cancel_d        = cancel_q;
        cancel_pc_d     = cancel_pc_q;
        instruction_out = 32'h0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (redirect) pc_d = target;
            end
            FETCH: begin
                if (!complete) begin
                    // Address must stay stable; remember where to go once the
                    // in-flight request returns.
                    if (redirect) begin
                        cancel_d    = 1'b1;
                        cancel_pc_d = target;
                    end
                end else if (redirect) begin
                    pc_d     = target;
                    cancel_d = 1'b0;
                end else if (cancel_q) begin
                    pc_d     = cancel_pc_q;
                    cancel_d = 1'b0;
                end else begin
                    instruction_out = imem_rdata;
                    if (stall) begin
                        hold_buf_d = imem_rdata;
                        state_d    = HOLD;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = FETCH;
                end else begin
                    instruction_out = hold_buf_q;
                    if (!stall) begin
                        pc_d    = pc_plus4;
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            pc_q        <= RESET_PC;
            state_q     <= IDLE;
            hold_buf_q  <= 32'h0;
            cancel_q    <= 1'b0;
            cancel_pc_q <= 32'h0;
        end else begin
            pc_q        <= pc_d;
            state_q     <= state_d;
            hold_buf_q  <= hold_buf_d;
            cancel_q    <= cancel_d;
            cancel_pc_q <= cancel_pc_d;
        end
    end

endmodule
